gate_response_checker: RTL and testbench

- Self-running stimulus and response checker for a 2-input, 1-output combinational gate. Default truth table is NOR.
- Drives inputs a/b through all four vectors (00, 01, 10, 11), waits a settle interval, samples c, and compares it against a parameterised truth table.
- Accumulates mismatch statistics and reports pass/fail. Sits beside the gate as an on-chip built-in self-test (BIST) for the gate.

---
 rtl/gate_response_checker_if.sv | 25 ++
 rtl/gate_response_checker.sv | 145 ++++++++++++++
 tb/tb_gate_response_checker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_response_checker_if.sv
// Control, status and gate-stimulus signals of the gate response checker.
// The slave side is the checker; the master side is whatever drives start/stop and returns c.
interface gate_response_checker_if;
    logic       start;
    logic       stop;
    logic       c;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [3:0] fail_vec;
    logic [1:0] vec_idx;

    modport slave (
        input  start, stop, c,
        output a, b, busy, done, pass, err_count, fail_vec, vec_idx
    );

    modport master (
        output start, stop, c,
        input  a, b, busy, done, pass, err_count, fail_vec, vec_idx
    );
endinterface

// File: rtl/gate_response_checker.sv
// BIST for a 2-in/1-out gate: walks {a,b} through 00..11, samples c after SETTLE_CYCLES, tallies mismatches.
// Each vector takes SETTLE_CYCLES+2 clocks; done follows the last vector by one clock; no backpressure.
module gate_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT_TABLE  = 4'b0001,
    parameter int unsigned LOOPS         = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_response_checker_if.slave bus
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LOOPS_W     = 16'(LOOPS);
    localparam bit          LOOPS_EN    = (LOOPS != 0);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        NEXT,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] loop_cnt_q, loop_cnt_d;
    logic [15:0] loop_cnt_inc;
    logic [1:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [7:0]  err_q, err_d;
    logic [3:0]  fail_q, fail_d;
    logic        stop_pend_q, stop_pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            loop_cnt_q   <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_q       <= '0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            loop_cnt_q   <= loop_cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_q       <= fail_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        loop_cnt_d   = loop_cnt_q;
        loop_cnt_inc = loop_cnt_q + 16'd1;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_d       = fail_q;
        stop_pend_d  = stop_pend_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d        = '0;
                    fail_d       = '0;
                    vec_d        = 2'd0;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    loop_cnt_d   = '0;
                    settle_cnt_d = '0;
                    // A stop seen together with start must still end the first pass.
                    stop_pend_d  = bus.stop;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (bus.c != EXPECT_TABLE[vec_q]) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    fail_d[vec_q] = 1'b1;
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = SETTLE;
                end else begin
                    loop_cnt_d  = loop_cnt_inc;
                    vec_d       = 2'd0;
                    stop_pend_d = 1'b0;
                    if (bus.stop || stop_pend_q || (LOOPS_EN && (loop_cnt_inc == LOOPS_W))) begin
                        // Result flags are registered here so they appear alongside done.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_q == 8'd0);
                        state_d = FINISH;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.a         = vec_q[1];
    assign bus.b         = vec_q[0];
    assign bus.vec_idx   = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: three instances (LOOPS=1, LOOPS=3, LOOPS=0) each check a gate
// whose truth table the bench chooses; expectations come from truth-table arithmetic.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gate_response_checker_if if1();
    gate_response_checker_if if3();
    gate_response_checker_if if0();

    logic [3:0] g1, g3, g0;
    assign if1.c = g1[{if1.a, if1.b}];
    assign if3.c = g3[{if3.a, if3.b}];
    assign if0.c = g0[{if0.a, if0.b}];

    logic [18:0] st1, st3, st0;
    assign st1 = {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_vec, if1.vec_idx};
    assign st3 = {if3.a, if3.b, if3.busy, if3.done, if3.pass, if3.err_count, if3.fail_vec, if3.vec_idx};
    assign st0 = {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_vec, if0.vec_idx};

    gate_response_checker #(.SETTLE_CYCLES(2), .EXPECT_TABLE(4'b0001), .LOOPS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    gate_response_checker #(.SETTLE_CYCLES(3), .EXPECT_TABLE(4'b0001), .LOOPS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));
    gate_response_checker #(.SETTLE_CYCLES(2), .EXPECT_TABLE(4'b0001), .LOOPS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));

    localparam logic [3:0] NOR_TBL = 4'b0001;

    function automatic int ones(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (st1 !== 19'd0) begin errors++; $display("FAIL reset_dut1 got %h want 0", st1); end
        checks++; if (st3 !== 19'd0) begin errors++; $display("FAIL reset_dut3 got %h want 0", st3); end
        checks++; if (st0 !== 19'd0) begin errors++; $display("FAIL reset_dut0 got %h want 0", st0); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (st1 !== 19'd0) begin errors++; $display("FAIL post_reset_idle got %h want 0", st1); end
    endtask

    // LOOPS=1, SETTLE=2: correct NOR, c stuck at 0, then random gates.
    task automatic test_single_pass;
        logic [3:0] tbl, mis;
        int lat, exp_err;
        for (int it = 0; it < 8; it++) begin
            tbl = (it == 0) ? NOR_TBL : (it == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
            g1 = tbl;
            mis = tbl ^ NOR_TBL;
            exp_err = ones(mis);
            lat = 0;
            @(negedge clk);
            if1.start = 1'b1;
            for (int k = 1; k <= 40 && lat == 0; k++) begin
                @(negedge clk);
                if1.start = 1'b0;
                if (it == 0 && k < 17) begin
                    checks++;
                    if ({if1.a, if1.b, if1.vec_idx, if1.busy} !== {2'((k - 1) / 4), 2'((k - 1) / 4), 1'b1}) begin
                        errors++;
                        $display("FAIL seq_k%0d got ab=%b%b idx=%0d busy=%b want vec=%0d busy=1",
                                 k, if1.a, if1.b, if1.vec_idx, if1.busy, (k - 1) / 4);
                    end
                end
                if (if1.done === 1'b1) lat = k;
            end
            checks++; if (lat != 17) begin errors++; $display("FAIL single_latency it%0d got %0d want 17", it, lat); end
            checks++; if (if1.err_count !== 8'(exp_err)) begin errors++; $display("FAIL single_err it%0d got %0d want %0d", it, if1.err_count, exp_err); end
            checks++; if (if1.fail_vec !== mis) begin errors++; $display("FAIL single_failvec it%0d got %b want %b", it, if1.fail_vec, mis); end
            checks++; if (if1.pass !== (exp_err == 0)) begin errors++; $display("FAIL single_pass it%0d got %b want %b", it, if1.pass, exp_err == 0); end
            checks++; if ({if1.busy, if1.a, if1.b} !== 3'b000) begin errors++; $display("FAIL single_final_busy_ab it%0d got %b want 000", it, {if1.busy, if1.a, if1.b}); end
            @(negedge clk);
            checks++; if (if1.done !== 1'b0) begin errors++; $display("FAIL single_done_width it%0d got %b want 0", it, if1.done); end
        end
    endtask

    // LOOPS=3, SETTLE=3: AND gate first, then random gates; one done after three passes.
    task automatic test_multi_loop;
        logic [3:0] tbl, mis;
        int lat, dn, exp_err;
        for (int it = 0; it < 4; it++) begin
            tbl = (it == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
            g3 = tbl;
            mis = tbl ^ NOR_TBL;
            exp_err = 3 * ones(mis);
            lat = 0;
            dn = 0;
            @(negedge clk);
            if3.start = 1'b1;
            for (int k = 1; k <= 75; k++) begin
                @(negedge clk);
                if3.start = 1'b0;
                if (if3.done === 1'b1) begin
                    dn++;
                    if (lat == 0) lat = k;
                end
                if (lat == k) begin
                    checks++; if (if3.err_count !== 8'(exp_err)) begin errors++; $display("FAIL multi_err it%0d got %0d want %0d", it, if3.err_count, exp_err); end
                    checks++; if (if3.fail_vec !== mis) begin errors++; $display("FAIL multi_failvec it%0d got %b want %b", it, if3.fail_vec, mis); end
                    checks++; if (if3.pass !== (exp_err == 0)) begin errors++; $display("FAIL multi_pass it%0d got %b want %b", it, if3.pass, exp_err == 0); end
                end
            end
            checks++; if (lat != 61) begin errors++; $display("FAIL multi_latency it%0d got %0d want 61", it, lat); end
            checks++; if (dn != 1) begin errors++; $display("FAIL multi_done_count it%0d got %0d want 1", it, dn); end
        end
    endtask

    // LOOPS=0, inverted NOR, stop raised during vector 1 of pass 70.
    task automatic test_stop_saturate;
        int lat = 0;
        int stop_k = 69 * 16 + 6;
        int exp_err = 70 * ones(4'b1110 ^ NOR_TBL);
        if (exp_err > 255) exp_err = 255;
        g0 = 4'b1110;
        @(negedge clk);
        if0.start = 1'b1;
        for (int k = 1; k <= 1200 && lat == 0; k++) begin
            @(negedge clk);
            if0.start = 1'b0;
            if (k == stop_k) begin
                if0.stop = 1'b1;
                checks++; if ({if0.busy, if0.pass, if0.vec_idx} !== {1'b1, 1'b0, 2'd1}) begin errors++; $display("FAIL stop_midrun got busy=%b pass=%b idx=%0d want 1 0 1", if0.busy, if0.pass, if0.vec_idx); end
            end
            if (if0.done === 1'b1) lat = k;
        end
        checks++; if (lat != 70 * 16 + 1) begin errors++; $display("FAIL stop_latency got %0d want %0d", lat, 70 * 16 + 1); end
        checks++; if (if0.err_count !== 8'(exp_err)) begin errors++; $display("FAIL stop_saturate got %0d want %0d", if0.err_count, exp_err); end
        checks++; if ({if0.fail_vec, if0.pass} !== 5'b11110) begin errors++; $display("FAIL stop_failvec_pass got %b want 11110", {if0.fail_vec, if0.pass}); end
        if0.stop = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if ({if0.busy, if0.done, if0.err_count} !== {2'b00, 8'(exp_err)}) begin errors++; $display("FAIL stop_hold got %h want %h", {if0.busy, if0.done, if0.err_count}, {2'b00, 8'(exp_err)}); end
    endtask

    // Reset while vector 2 is applied aborts the run; a fresh run is then normal.
    task automatic test_reset_midrun;
        int found = 0, dn = 0, lat = 0;
        g1 = 4'b0000;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (if1.vec_idx === 2'd2) found = 1;
            else @(negedge clk);
        end
        checks++; if (found != 1 || if1.err_count !== 8'd1) begin errors++; $display("FAIL midrun_prereset got found=%0d err=%0d want 1 1", found, if1.err_count); end
        rst_n = 1'b0;
        #1;
        checks++; if (st1 !== 19'd0) begin errors++; $display("FAIL midrun_async_reset got %h want 0", st1); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (if1.done === 1'b1) dn++;
        end
        checks++; if (dn != 0 || st1 !== 19'd0) begin errors++; $display("FAIL midrun_no_done got dn=%0d st=%h want 0 0", dn, st1); end
        g1 = NOR_TBL;
        if1.start = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if1.start = 1'b0;
            if (if1.done === 1'b1) lat = k;
        end
        checks++; if (lat != 17) begin errors++; $display("FAIL midrun_fresh_latency got %0d want 17", lat); end
        checks++; if ({if1.pass, if1.err_count, if1.fail_vec} !== {1'b1, 8'd0, 4'd0}) begin errors++; $display("FAIL midrun_fresh_result got %h want %h", {if1.pass, if1.err_count, if1.fail_vec}, {1'b1, 8'd0, 4'd0}); end
    endtask

    // Start while busy is ignored; start+stop together runs exactly one pass.
    task automatic test_back_to_back;
        int lat = 0, dn = 0;
        g1 = NOR_TBL;
        @(negedge clk);
        if1.start = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if1.start = (k == 6);
            if (if1.done === 1'b1) begin
                dn++;
                if (lat == 0) lat = k;
            end
        end
        checks++; if (lat != 17) begin errors++; $display("FAIL busy_start_latency got %0d want 17", lat); end
        checks++; if (dn != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", dn); end

        g0 = NOR_TBL;
        lat = 0;
        dn = 0;
        @(negedge clk);
        if0.start = 1'b1;
        if0.stop  = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if0.start = 1'b0;
            if0.stop  = 1'b0;
            if (if0.done === 1'b1) begin
                dn++;
                if (lat == 0) lat = k;
            end
        end
        checks++; if (lat != 17) begin errors++; $display("FAIL start_stop_latency got %0d want 17", lat); end
        checks++; if (dn != 1) begin errors++; $display("FAIL start_stop_done_count got %0d want 1", dn); end
        checks++; if ({if0.pass, if0.err_count, if0.busy} !== {1'b1, 8'd0, 1'b0}) begin errors++; $display("FAIL start_stop_result got %h want %h", {if0.pass, if0.err_count, if0.busy}, {1'b1, 8'd0, 1'b0}); end
    endtask

    initial begin
        if1.start = 1'b0; if1.stop = 1'b0;
        if3.start = 1'b0; if3.stop = 1'b0;
        if0.start = 1'b0; if0.stop = 1'b0;
        g1 = NOR_TBL; g3 = NOR_TBL; g0 = NOR_TBL;
        test_reset();
        test_single_pass();
        test_multi_loop();
        test_stop_saturate();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
